prescaler_prog: RTL
===================

// Module: prescaler_prog
// PURPOSE
//   Runtime-programmable clock-enable prescaler. Generalises the fixed-ratio
//   prescaler with a WIDTH-bit divisor that software or logic can reload at
//   runtime, a periodic/one-shot mode, and status outputs.
//   Sits between the system clock domain and any logic clocked by CEO as a
//   clock enable (timers, UART baud ticks, display scan, debouncers).
// PARAMETERS
//   WIDTH        16  width of the divisor and counter
//   DEFAULT_DIV  10  divisor loaded at reset; must be < 2**WIDTH
// PORTS
//   CLK          in   1      system clock, all logic on rising edge
//   CLR_N        in   1      reset, synchronous, active-low
//   CE           in   1      input clock enable; the counter only advances when CE=1
//   DIV_IN       in   WIDTH  new divisor value N (divide CE by N)
//   DIV_LOAD     in   1      1-cycle strobe: capture DIV_IN into the shadow register
//   MODE         in   1      0 = periodic, 1 = one-shot
//   START        in   1      one-shot trigger (ignored when MODE=0)
//   CEO          out  1      output enable pulse, one CLK cycle wide
//   COUNT        out  WIDTH  current counter value
//   BUSY         out  1      counter is running (always 1 in periodic mode after reset)
//   DIV_PENDING  out  1      shadow divisor captured but not yet applied
// BEHAVIOUR
//   Reset (CLR_N=0 at a rising edge):
//     - COUNT=0; active and shadow divisor = DEFAULT_DIV; DIV_PENDING=0.
//     - State = IDLE; BUSY=0; CEO forced 0 while CLR_N=0.
//     - Reset mid-count aborts immediately; there is no partial pulse.
//   Divisor:
//     - N = active divisor; TC = N-1, except N=0 is treated as N=1 (TC=0).
//     - N<=1: CEO follows CE every cycle while running.
//   Running:
//     - run = (MODE==0) | (state==RUN).
//     - BUSY is registered and equals run.
//   CEO:
//     - Combinational: CEO = CE & run & (COUNT==TC) & CLR_N. Zero latency from CE.
//   Counter:
//     - If run & CE: COUNT <= (COUNT==TC) ? 0 : COUNT+1.
//     - Otherwise COUNT holds.
//     - Arithmetic is unsigned WIDTH-bit. COUNT never exceeds TC, except
//       transiently after a divisor change (see below).
//   Shadow load:
//     - DIV_LOAD=1: shadow <= DIV_IN and DIV_PENDING <= 1.
//     - A later DIV_LOAD before the transfer overwrites the shadow (last one wins).
//   Transfer shadow -> active:
//     - Happens on the cycle CEO=1 (wrap), or on any cycle with run=0.
//     - DIV_PENDING clears on transfer.
//     - DIV_LOAD on the same cycle as a transfer: DIV_IN bypasses straight to
//       active and DIV_PENDING stays 0.
//     - The period in progress always completes with the old divisor;
//       no glitch, no short period.
//   State machine (one-shot, MODE=1):
//     - IDLE: START=1 -> RUN, COUNT=0.
//     - RUN: the cycle with CEO=1 -> IDLE, COUNT=0.
//     - START while in RUN is ignored. One CEO pulse per START.
//     - START and CE on the same cycle: the counter starts on the next cycle;
//       the START cycle does not count.
//   Mode change:
//     - A registered copy of MODE detects the edge.
//     - Any MODE change -> COUNT=0 and state=IDLE on the following cycle.
//     - CEO is suppressed on that detection cycle.
// TESTING
//   1. Reset, MODE=0, CE=1 constant, default divisor 10 -> CEO high on every
//      10th cycle, COUNT runs 0..9 and wraps, BUSY=1.
//   2. Default divisor, CE toggling 1/0 each cycle -> CEO every 20 CLK cycles,
//      always coincident with CE=1, width 1 cycle.
//   3. DIV_LOAD with DIV_IN=4 at COUNT=3 -> DIV_PENDING=1 until the wrap at 9,
//      then period 4 (COUNT 0..3), DIV_PENDING=0. Repeat with DIV_LOAD on the
//      wrap cycle -> period 4 starts immediately, DIV_PENDING stays 0.
//   4. DIV_IN=1, then DIV_IN=0 (each loaded) -> CEO==CE every cycle, COUNT stays 0.
//   5. MODE=1, divisor 5, START pulse, CE=1 -> exactly one CEO five cycles after
//      start, BUSY high for 5 cycles then 0. Second START mid-run has no effect.
//      No further CEO without a new START.
//   6. CLR_N=0 for one cycle at COUNT=6 with shadow=3 pending -> next cycle
//      COUNT=0, divisor 10, DIV_PENDING=0, no CEO during reset.

Source files
------------

// File: rtl/prescaler_prog.sv
// -----------------------------------------------------------------------------
// prescaler_prog
//   Runtime-programmable clock-enable prescaler. Divides the CE input by a
//   WIDTH-bit divisor N and emits a one-CLK-wide enable pulse (CEO) every N
//   qualified CE cycles. The divisor is written through a shadow register so a
//   period in progress always finishes with the divisor it started with.
//   MODE selects free-running periodic operation or one-shot operation, where
//   each START produces exactly one CEO pulse.
//
// Ports
//   CLK          system clock, all logic on the rising edge
//   CLR_N        synchronous active-low reset
//   CE           input enable; the counter only advances when CE=1
//   DIV_IN       new divisor value N
//   DIV_LOAD     one-cycle strobe capturing DIV_IN into the shadow register
//   MODE         0 = periodic, 1 = one-shot
//   START        one-shot trigger (ignored when MODE=0)
//   CEO          output enable pulse, combinational from CE
//   COUNT        current counter value
//   BUSY         registered copy of the running condition
//   DIV_PENDING  shadow divisor captured but not yet applied
// -----------------------------------------------------------------------------
module prescaler_prog #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_LOAD,
    input  logic             MODE,
    input  logic             START,
    output logic             CEO,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             DIV_PENDING
);

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shadow;
    logic [WIDTH-1:0] tc;
    logic             mode_q;
    logic             mode_chg;
    logic             run;
    logic             at_tc;
    logic             wrap;
    logic             xfer;
    logic             busy_nxt;

    // Datapath decode: terminal count, running condition and the wrap pulse.
    always_comb begin
        // A divisor of 0 behaves like 1: the counter stays at 0 and CEO follows CE.
        tc       = (div_act == '0) ? '0 : div_act - WIDTH'(1);
        mode_chg = MODE ^ mode_q;
        run      = !MODE || (state == RUN);
        at_tc    = (COUNT == tc);
        // The cycle that detects a MODE change never produces a pulse.
        wrap     = CE && run && at_tc && !mode_chg;
        CEO      = wrap && CLR_N;
        // The shadow divisor may only replace the active one at a period
        // boundary or while nothing is counting, so no short period is emitted.
        xfer     = wrap || !run;
    end

    // Next-state / next-count logic for the one-shot controller and counter.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that leaves
        // one unassigned would infer a latch.
        state_nxt = state;
        count_nxt = COUNT;

        if (run && CE) begin
            count_nxt = at_tc ? '0 : COUNT + WIDTH'(1);
        end

        if (mode_chg) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // The START cycle itself is not counted: run is still 0 here.
                    if (MODE && START) begin
                        state_nxt = RUN;
                        count_nxt = '0;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // BUSY is registered, so it is computed from the state being entered.
        busy_nxt = !MODE || (state_nxt == RUN);
    end

    // NOTE: reset is synchronous and active-low, checked first inside the clocked
    // block; state is updated only with non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state       <= IDLE;
            COUNT       <= '0;
            div_act     <= DIV_RESET;
            div_shadow  <= DIV_RESET;
            DIV_PENDING <= 1'b0;
            BUSY        <= 1'b0;
            // Track MODE through reset so leaving reset is not seen as a change.
            mode_q      <= MODE;
        end else begin
            state  <= state_nxt;
            COUNT  <= count_nxt;
            BUSY   <= busy_nxt;
            mode_q <= MODE;

            if (DIV_LOAD) begin
                div_shadow <= DIV_IN;
            end

            if (xfer) begin
                // A load coinciding with a transfer bypasses the shadow.
                div_act     <= DIV_LOAD ? DIV_IN : div_shadow;
                DIV_PENDING <= 1'b0;
            end else if (DIV_LOAD) begin
                DIV_PENDING <= 1'b1;
            end
        end
    end

endmodule
